// File: rtl/bc_io_unit.sv
// bc_io_unit: basic-computer character I/O responder (INPR/OUTR, FGI/FGO, IEN, R).
module bc_io_unit #(
    parameter int WIDTH  = 16,
    parameter int CHAR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              io_en,
    input  logic [5:0]        io_sel,
    input  logic [WIDTH-1:0]  ac_in,
    input  logic              r_set_en,
    input  logic              int_ack,
    output logic [CHAR_W-1:0] inpr,
    output logic              skip,
    output logic              fgi,
    output logic              fgo,
    output logic              ien,
    output logic              int_req,
    output logic              tx_overrun,
    input  logic [CHAR_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [CHAR_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);
    typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
    tx_state_t state, state_nxt;
    logic [CHAR_W-1:0] outr;
    logic sel_inp, sel_out, sel_ski, sel_sko, sel_ion, sel_iof, rx_fire;
    logic unused_ac;
    assign unused_ac = ^ac_in[WIDTH-1:CHAR_W];
    assign sel_inp  = io_en & io_sel[5];
    assign sel_out  = io_en & io_sel[5:4] == 2'b01;
    assign sel_ski  = io_en & io_sel[5:3] == 3'b001;
    assign sel_sko  = io_en & io_sel[5:2] == 4'b0001;
    assign sel_ion  = io_en & io_sel[5:1] == 5'b00001;
    assign sel_iof  = io_en & io_sel == 6'b000001;
    assign rx_ready = ~fgi;
    assign rx_fire  = rx_valid & ~fgi;
    assign skip     = (sel_ski & fgi) | (sel_sko & fgo);
    assign fgo      = state == TX_IDLE;
    assign tx_valid = state == TX_SEND;
    assign tx_data  = outr;
    always_comb begin
        state_nxt = state;
        state_nxt = state == TX_IDLE ? (sel_out ? TX_SEND : TX_IDLE)
                                     : (tx_ready ? TX_IDLE : TX_SEND);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= TX_IDLE;
            outr       <= '0;
            inpr       <= '0;
            fgi        <= 1'b0;
            ien        <= 1'b0;
            int_req    <= 1'b0;
            tx_overrun <= 1'b0;
        end else begin
            state <= state_nxt;
            if (sel_out && state == TX_IDLE) outr <= ac_in[CHAR_W-1:0];
            if (rx_fire) inpr <= rx_data;
            fgi        <= rx_fire | (fgi & ~sel_inp);
            ien        <= ~int_ack & (sel_ion | (ien & ~sel_iof));
            int_req    <= ~int_ack & (int_req | (r_set_en & ien & (fgi | fgo)));
            tx_overrun <= tx_overrun | (sel_out & state == TX_SEND);
        end
    end
endmodule
